// File: rtl/ara_w_trace_collector.sv
// ara_w_trace_collector
// Snoops the AXI W channels of several Ara clusters. Inside a trigger-controlled
// window it captures strobe-qualified beats into one FIFO per channel. The FIFO
// heads are merged round-robin into a single valid/ready record stream.
// Per-channel byte counters, a drop counter and a sticky overflow flag are kept.
module ara_w_trace_collector #(
  parameter int unsigned NrChannels = 4,
  parameter int unsigned DataWidth  = 128,
  parameter int unsigned FifoDepth  = 8,
  parameter int unsigned CntWidth   = 32,
  parameter logic [63:0] TriggerOn  = 64'h1,
  parameter logic [63:0] TriggerOff = 64'hFFFF_FFFF_FFFF_FFFF,
  localparam int unsigned StrbWidth = DataWidth / 8,
  localparam int unsigned ChanWidth = (NrChannels > 1) ? $clog2(NrChannels) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             clear_i,
  input  logic [63:0]                      trigger_i,
  input  logic                             cnt_en_i,
  input  logic [NrChannels*DataWidth-1:0]  w_data_i,
  input  logic [NrChannels*StrbWidth-1:0]  w_strb_i,
  input  logic [NrChannels-1:0]            w_valid_i,
  input  logic [NrChannels-1:0]            w_ready_i,
  output logic                             rec_valid_o,
  input  logic                             rec_ready_i,
  output logic [ChanWidth-1:0]             rec_chan_o,
  output logic [DataWidth-1:0]             rec_data_o,
  output logic [StrbWidth-1:0]             rec_strb_o,
  output logic                             active_o,
  output logic [NrChannels*CntWidth-1:0]   byte_cnt_o,
  output logic [CntWidth-1:0]              drop_cnt_o,
  output logic                             overflow_o
);

  localparam int unsigned PtrWidth  = $clog2(FifoDepth);
  localparam int unsigned LvlWidth  = PtrWidth + 1;
  localparam int unsigned PopWidth  = $clog2(StrbWidth + 1);
  localparam int unsigned DropWidth = $clog2(NrChannels + 1);
  localparam logic [LvlWidth-1:0]  LvlFull  = LvlWidth'(FifoDepth);
  localparam logic [ChanWidth:0]   NrChanW  = (ChanWidth + 1)'(NrChannels);
  localparam logic [ChanWidth-1:0] LastChan = ChanWidth'(NrChannels - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_STOPPED
  } state_e;

  state_e r_state;
  logic   r_active;

  logic                  w_clr;
  logic                  w_armed;
  logic [NrChannels-1:0] w_capture;
  logic [NrChannels-1:0] w_push;
  logic [NrChannels-1:0] w_drop;
  logic [NrChannels-1:0] w_pop;
  logic [NrChannels-1:0] w_nonempty;
  logic [DataWidth-1:0]  w_head_data [NrChannels];
  logic [StrbWidth-1:0]  w_head_strb [NrChannels];

  logic [ChanWidth-1:0]  r_rr_ptr;
  logic [ChanWidth-1:0]  r_hold_chan;
  logic                  r_hold;
  logic [ChanWidth-1:0]  w_rr_pick;
  logic [ChanWidth-1:0]  w_grant;
  logic [ChanWidth:0]    w_cand;
  logic                  w_any;
  logic                  w_handshake;

  logic [DropWidth-1:0]  w_drop_num;
  logic [CntWidth:0]     w_drop_sum;
  logic [CntWidth-1:0]   r_drop_cnt;
  logic                  r_overflow;

  // Reset and clear share one synchronous path; clear wins over every other event.
  assign w_clr   = !rst_ni || clear_i;
  // Capture is qualified by the registered state, so the trigger-on beat is
  // missed and the trigger-off beat is still taken.
  assign w_armed = (r_state == ST_ARMED);

  // Window FSM: IDLE -> ARMED on TriggerOn, ARMED -> STOPPED on TriggerOff.
  always_ff @(posedge clk_i) begin
    if (w_clr) begin
      r_state  <= ST_IDLE;
      r_active <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (trigger_i == TriggerOn) begin
            r_state  <= ST_ARMED;
            r_active <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (trigger_i == TriggerOff) begin
            r_state  <= ST_STOPPED;
            r_active <= 1'b0;
          end
        end
        ST_STOPPED: begin
          r_state  <= ST_STOPPED;
          r_active <= 1'b0;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign active_o = r_active;

  for (genvar gi = 0; gi < NrChannels; gi++) begin : g_chan
    logic [DataWidth-1:0] w_beat_data;
    logic [StrbWidth-1:0] w_beat_strb;
    logic [DataWidth-1:0] r_data_mem [FifoDepth];
    logic [StrbWidth-1:0] r_strb_mem [FifoDepth];
    logic [PtrWidth-1:0]  r_wptr;
    logic [PtrWidth-1:0]  r_rptr;
    logic [LvlWidth-1:0]  r_level;
    logic [PopWidth-1:0]  w_popcnt;
    logic [CntWidth:0]    w_byte_sum;
    logic [CntWidth-1:0]  r_byte_cnt;

    assign w_beat_data = w_data_i[gi*DataWidth +: DataWidth];
    assign w_beat_strb = w_strb_i[gi*StrbWidth +: StrbWidth];

    assign w_capture[gi]  = w_armed && cnt_en_i && w_valid_i[gi] && w_ready_i[gi]
                            && (|w_beat_strb);
    // Fullness uses the registered level only: a same-cycle pop does not make room.
    assign w_push[gi]     = w_capture[gi] && (r_level != LvlFull);
    assign w_drop[gi]     = w_capture[gi] && (r_level == LvlFull);
    assign w_nonempty[gi] = (r_level != '0);
    assign w_pop[gi]      = w_handshake && (w_grant == ChanWidth'(gi));

    assign w_head_data[gi] = r_data_mem[r_rptr];
    assign w_head_strb[gi] = r_strb_mem[r_rptr];

    // Beat storage; unreset because only occupied slots are ever presented.
    always_ff @(posedge clk_i) begin
      if (w_push[gi]) begin
        r_data_mem[r_wptr] <= w_beat_data;
        r_strb_mem[r_wptr] <= w_beat_strb;
      end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i) begin
      if (w_clr) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_level <= '0;
      end else begin
        if (w_push[gi]) r_wptr <= r_wptr + PtrWidth'(1);
        if (w_pop[gi])  r_rptr <= r_rptr + PtrWidth'(1);
        case ({w_push[gi], w_pop[gi]})
          2'b10:   r_level <= r_level + LvlWidth'(1);
          2'b01:   r_level <= r_level - LvlWidth'(1);
          default: r_level <= r_level;
        endcase
      end
    end

    // Number of enabled byte lanes in the snooped beat.
    always_comb begin
      w_popcnt = '0;
      for (int b = 0; b < StrbWidth; b++) begin
        w_popcnt = w_popcnt + PopWidth'(w_beat_strb[b]);
      end
    end

    assign w_byte_sum = {1'b0, r_byte_cnt} + (CntWidth + 1)'(w_popcnt);

    // Saturating byte counter; counts captured beats even when they are dropped.
    always_ff @(posedge clk_i) begin
      if (w_clr) begin
        r_byte_cnt <= '0;
      end else if (w_capture[gi]) begin
        r_byte_cnt <= w_byte_sum[CntWidth] ? '1 : w_byte_sum[CntWidth-1:0];
      end
    end

    assign byte_cnt_o[gi*CntWidth +: CntWidth] = r_byte_cnt;
  end

  // Number of channels that dropped a beat this cycle.
  always_comb begin
    w_drop_num = '0;
    for (int c = 0; c < NrChannels; c++) begin
      w_drop_num = w_drop_num + DropWidth'(w_drop[c]);
    end
  end

  assign w_drop_sum = {1'b0, r_drop_cnt} + (CntWidth + 1)'(w_drop_num);

  // Saturating drop counter and sticky overflow flag.
  always_ff @(posedge clk_i) begin
    if (w_clr) begin
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else if (|w_drop) begin
      r_drop_cnt <= w_drop_sum[CntWidth] ? '1 : w_drop_sum[CntWidth-1:0];
      r_overflow <= 1'b1;
    end
  end

  assign drop_cnt_o = r_drop_cnt;
  assign overflow_o = r_overflow;

  // First non-empty FIFO at or after the round-robin pointer.
  always_comb begin
    w_rr_pick = r_rr_ptr;
    w_any     = 1'b0;
    w_cand    = '0;
    for (int i = 0; i < NrChannels; i++) begin
      w_cand = {1'b0, r_rr_ptr} + (ChanWidth + 1)'(i);
      if (w_cand >= NrChanW) w_cand = w_cand - NrChanW;
      if (!w_any && w_nonempty[w_cand[ChanWidth-1:0]]) begin
        w_rr_pick = w_cand[ChanWidth-1:0];
        w_any     = 1'b1;
      end
    end
  end

  // A stalled record keeps its grant even if a FIFO earlier in the rotation
  // fills up meanwhile; a held FIFO cannot drain, so it stays non-empty.
  assign w_grant     = r_hold ? r_hold_chan : w_rr_pick;
  assign w_handshake = w_any && rec_ready_i;

  assign rec_valid_o = w_any;
  assign rec_chan_o  = w_grant;
  assign rec_data_o  = w_head_data[w_grant];
  assign rec_strb_o  = w_head_strb[w_grant];

  // Grant hold on stall and pointer advance past the served channel.
  always_ff @(posedge clk_i) begin
    if (w_clr) begin
      r_rr_ptr    <= '0;
      r_hold      <= 1'b0;
      r_hold_chan <= '0;
    end else begin
      r_hold      <= w_any && !rec_ready_i;
      r_hold_chan <= w_grant;
      if (w_handshake) begin
        r_rr_ptr <= (w_grant == LastChan) ? '0 : w_grant + ChanWidth'(1);
      end
    end
  end

endmodule

// File: tb/tb_ara_w_trace_collector.sv
// Directed bench for ara_w_trace_collector with a per-channel scoreboard.
module tb_ara_w_trace_collector;
  localparam int NC = 4;
  localparam int DW = 128;
  localparam int SW = DW / 8;
  localparam int CW = 32;
  localparam int FD = 8;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic              clear_i;
  logic [63:0]       trigger_i;
  logic              cnt_en_i;
  logic [NC*DW-1:0]  w_data_i;
  logic [NC*SW-1:0]  w_strb_i;
  logic [NC-1:0]     w_valid_i;
  logic [NC-1:0]     w_ready_i;
  logic              rec_valid_o;
  logic              rec_ready_i;
  logic [1:0]        rec_chan_o;
  logic [DW-1:0]     rec_data_o;
  logic [SW-1:0]     rec_strb_o;
  logic              active_o;
  logic [NC*CW-1:0]  byte_cnt_o;
  logic [CW-1:0]     drop_cnt_o;
  logic              overflow_o;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } rec_t;

  rec_t exp_q [NC][$];
  int   chan_log[$];
  int   n_recs = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ara_w_trace_collector #(
    .NrChannels(NC), .DataWidth(DW), .FifoDepth(FD), .CntWidth(CW),
    .TriggerOn(64'h1), .TriggerOff(64'hFFFF_FFFF_FFFF_FFFF)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .trigger_i(trigger_i),
    .cnt_en_i(cnt_en_i), .w_data_i(w_data_i), .w_strb_i(w_strb_i),
    .w_valid_i(w_valid_i), .w_ready_i(w_ready_i), .rec_valid_o(rec_valid_o),
    .rec_ready_i(rec_ready_i), .rec_chan_o(rec_chan_o), .rec_data_o(rec_data_o),
    .rec_strb_o(rec_strb_o), .active_o(active_o), .byte_cnt_o(byte_cnt_o),
    .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  function automatic logic [CW-1:0] bcnt(input int c);
    return byte_cnt_o[c*CW +: CW];
  endfunction

  function automatic int q_total();
    int t = 0;
    for (int c = 0; c < NC; c++) t += exp_q[c].size();
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int ch, input logic [DW-1:0] d, input logic [SW-1:0] s);
    w_valid_i[ch]           = 1'b1;
    w_ready_i[ch]           = 1'b1;
    w_data_i[ch*DW +: DW]   = d;
    w_strb_i[ch*SW +: SW]   = s;
  endtask

  task automatic expect_rec(input int ch, input logic [DW-1:0] d, input logic [SW-1:0] s);
    rec_t r;
    r.data = d;
    r.strb = s;
    exp_q[ch].push_back(r);
  endtask

  task automatic idle_w();
    w_valid_i = '0;
    w_ready_i = '0;
    w_data_i  = '0;
    w_strb_i  = '0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q_total() != 0 || rec_valid_o) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL drain_timeout: pending %0d expected 0", q_total());
    end
  endtask

  // Monitor: pops expected records on each handshake and checks stall stability.
  initial begin : monitor
    logic          stall_prev = 1'b0;
    logic [1:0]    p_chan = '0;
    logic [DW-1:0] p_data = '0;
    logic [SW-1:0] p_strb = '0;
    forever begin
      @(negedge clk);
      if (stall_prev) begin
        checks++;
        if (!(rec_valid_o === 1'b1 && rec_chan_o === p_chan && rec_data_o === p_data
              && rec_strb_o === p_strb)) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b ch=%0d d=%0h s=%0h expected ch=%0d d=%0h s=%0h",
                   rec_valid_o, rec_chan_o, rec_data_o, rec_strb_o, p_chan, p_data, p_strb);
        end
      end
      stall_prev = rst_ni && !clear_i && rec_valid_o && !rec_ready_i;
      p_chan = rec_chan_o;
      p_data = rec_data_o;
      p_strb = rec_strb_o;
      if (rst_ni && !clear_i && rec_valid_o === 1'b1 && rec_ready_i) begin
        int   c;
        rec_t e;
        c = int'(rec_chan_o);
        checks++;
        n_recs++;
        chan_log.push_back(c);
        if (exp_q[c].size() == 0) begin
          errors++;
          $display("FAIL record_unexpected: got ch=%0d d=%0h s=%0h expected none",
                   c, rec_data_o, rec_strb_o);
        end else begin
          e = exp_q[c].pop_front();
          if (rec_data_o !== e.data || rec_strb_o !== e.strb) begin
            errors++;
            $display("FAIL record_ch%0d: got d=%0h s=%0h expected d=%0h s=%0h",
                     c, rec_data_o, rec_strb_o, e.data, e.strb);
          end else begin
            $display("rec  ch=%0d d=%0h s=%0h", c, rec_data_o, rec_strb_o);
          end
        end
      end
    end
  end

  initial begin : stim
    logic [DW-1:0] d;
    rst_ni = 1'b0; clear_i = 1'b0; trigger_i = '0; cnt_en_i = 1'b1;
    rec_ready_i = 1'b1;
    idle_w();
    tick(); tick();
    rst_ni = 1'b1;
    tick();
    check("reset_valid", 128'(rec_valid_o), 128'd0);
    check("reset_active", 128'(active_o), 128'd0);
    check("reset_drop", 128'(drop_cnt_o), 128'd0);
    check("reset_ovf", 128'(overflow_o), 128'd0);

    // 1: IDLE beat ignored; trigger-on beat ignored; first armed beat captured
    set_beat(0, {4{32'hDEAD_BEEF}}, 16'hFFFF);
    tick(); idle_w();
    check("idle_bcnt0", 128'(bcnt(0)), 128'd0);
    check("idle_valid", 128'(rec_valid_o), 128'd0);
    trigger_i = 64'h1;
    set_beat(1, {4{32'h1111_1111}}, 16'hFFFF);
    tick(); idle_w(); trigger_i = '0;
    check("armed_active", 128'(active_o), 128'd1);
    check("trigon_bcnt1", 128'(bcnt(1)), 128'd0);
    d = 128'h0123_4567_89AB_CDEF_0011_2233_4455_66A1;
    set_beat(0, d, 16'h00F0);
    expect_rec(0, d, 16'h00F0);
    tick(); idle_w();
    check("first_bcnt0", 128'(bcnt(0)), 128'd4);
    check("first_latency_valid", 128'(rec_valid_o), 128'd1);
    drain();

    // 2: counter enable low, then a zero-strobe beat
    cnt_en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_beat(1, {4{32'h2222_0000 + 32'(i)}}, 16'hFFFF);
      tick();
    end
    idle_w();
    check("cnten_valid", 128'(rec_valid_o), 128'd0);
    check("cnten_bcnt1", 128'(bcnt(1)), 128'd0);
    cnt_en_i = 1'b1;
    set_beat(1, {4{32'h2222_FFFF}}, 16'h0000);
    tick(); idle_w();
    check("zstrb_bcnt1", 128'(bcnt(1)), 128'd0);
    check("zstrb_valid", 128'(rec_valid_o), 128'd0);

    // 3: overflow on channel 2 with the sink stalled
    rec_ready_i = 1'b0;
    n_recs = 0;
    for (int i = 0; i < 10; i++) begin
      d = {4{32'hC0DE_0000 + 32'(i)}};
      set_beat(2, d, 16'hFFFF);
      if (i < FD) expect_rec(2, d, 16'hFFFF);
      tick();
    end
    idle_w();
    check("ovf_drop", 128'(drop_cnt_o), 128'd2);
    check("ovf_flag", 128'(overflow_o), 128'd1);
    check("ovf_bcnt2", 128'(bcnt(2)), 128'd160);
    check("ovf_head_chan", 128'(rec_chan_o), 128'd2);
    rec_ready_i = 1'b1;
    drain();
    check("ovf_nrecs", 128'(n_recs), 128'd8);
    check("ovf_sticky", 128'(overflow_o), 128'd1);

    // 4: clear, re-arm, all channels at once with a mid-stream stall
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    check("clr_ovf", 128'(overflow_o), 128'd0);
    check("clr_drop", 128'(drop_cnt_o), 128'd0);
    check("clr_active", 128'(active_o), 128'd0);
    trigger_i = 64'h1; tick(); trigger_i = '0;
    chan_log.delete();
    for (int c = 0; c < NC; c++) begin
      d = {4{32'hA000_0000 + 32'(c)}};
      set_beat(c, d, 16'hFFFF);
      expect_rec(c, d, 16'hFFFF);
    end
    tick(); idle_w();
    tick();
    rec_ready_i = 1'b0;
    tick(); tick(); tick();
    rec_ready_i = 1'b1;
    drain();
    check("rr_count", 128'(chan_log.size()), 128'd4);
    for (int i = 0; i < NC; i++) begin
      check($sformatf("rr_order%0d", i), (chan_log.size() > i) ? 128'(chan_log[i]) : 128'hFF,
            128'(i));
    end

    // 5: trigger-off beat captured, then window closed for good
    trigger_i = 64'hFFFF_FFFF_FFFF_FFFF;
    d = {4{32'h3333_0003}};
    set_beat(3, d, 16'h000F);
    expect_rec(3, d, 16'h000F);
    rec_ready_i = 1'b0;
    tick(); idle_w(); trigger_i = '0;
    check("stop_active", 128'(active_o), 128'd0);
    check("stop_bcnt3", 128'(bcnt(3)), 128'd20);
    set_beat(3, {4{32'h3333_FFFF}}, 16'hFFFF);
    tick(); idle_w();
    check("stopped_bcnt3", 128'(bcnt(3)), 128'd20);
    trigger_i = 64'h1; tick(); trigger_i = '0;
    check("no_rearm", 128'(active_o), 128'd0);
    check("stopped_keeps_rec", 128'(rec_valid_o), 128'd1);
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    exp_q[3].delete();
    rec_ready_i = 1'b1;
    check("clr2_valid", 128'(rec_valid_o), 128'd0);
    check("clr2_bcnt3", 128'(bcnt(3)), 128'd0);
    check("clr2_bcnt0", 128'(bcnt(0)), 128'd0);
    check("clr2_active", 128'(active_o), 128'd0);

    // 6: reset with buffered entries
    trigger_i = 64'h1; tick(); trigger_i = '0;
    rec_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_beat(0, {4{32'h5555_0000 + 32'(i)}}, 16'hFFFF);
      tick();
    end
    idle_w();
    check("pre_rst_valid", 128'(rec_valid_o), 128'd1);
    check("pre_rst_bcnt0", 128'(bcnt(0)), 128'd80);
    rst_ni = 1'b0; tick(); rst_ni = 1'b1;
    check("rst_valid", 128'(rec_valid_o), 128'd0);
    check("rst_active", 128'(active_o), 128'd0);
    check("rst_bcnt0", 128'(bcnt(0)), 128'd0);
    check("rst_drop", 128'(drop_cnt_o), 128'd0);
    check("rst_ovf", 128'(overflow_o), 128'd0);
    rec_ready_i = 1'b1;
    tick(); tick(); tick();
    check("rst_fifo_empty", 128'(rec_valid_o), 128'd0);
    check("scoreboard_empty", 128'(q_total()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time %0t limit 200000", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule
